// File: rtl/seq_detect_ctrl.sv
// Programmable serial sequence detector: holds a shadow pattern/length/overlap/limit/timeout
// configuration and runs an arm -> hunt -> done sequence over a qualified serial bit stream.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8,
  parameter int TO_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_limit,
  input  logic [TO_W-1:0]    cfg_timeout,
  input  logic               start,
  input  logic               abort,
  input  logic               data_valid,
  input  logic               data_in,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic               timeout_flag,
  output logic               cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HUNT, S_DONE} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t             state_reg, state_next;

  logic [MAX_LEN-1:0] pattern_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               overlap_reg;
  logic [CNT_W-1:0]   limit_reg;
  logic [TO_W-1:0]    timeout_reg;

  logic [MAX_LEN-1:0] history_reg;
  logic [LEN_W-1:0]   bits_seen_reg;
  logic               shifted_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [TO_W-1:0]    idle_reg;
  logic               detected_reg;
  logic               timeout_flag_reg;
  logic               cfg_err_reg;

  logic [MAX_LEN-1:0] len_mask;
  logic               pattern_eq;
  logic               match_hit;
  logic [CNT_W-1:0]   count_inc;
  logic [TO_W-1:0]    idle_inc;
  logic               limit_hit;
  logic               timeout_hit;
  logic               cfg_open;
  logic               cfg_legal;

  // Only the low len_reg bits of history take part in the compare.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    localparam logic [LEN_W-1:0] IDX = LEN_W'(gi);
    assign len_mask[gi] = (IDX < len_reg);
  end

  assign pattern_eq  = (((history_reg ^ pattern_reg) & len_mask) == '0);
  assign match_hit   = (state_reg == S_HUNT) && shifted_reg &&
                       (bits_seen_reg >= len_reg) && pattern_eq;
  assign count_inc   = (&count_reg) ? count_reg : count_reg + CNT_W'(1);
  assign idle_inc    = (&idle_reg) ? idle_reg : idle_reg + TO_W'(1);
  assign limit_hit   = (limit_reg != '0) && (count_inc == limit_reg);
  assign timeout_hit = (timeout_reg != '0) && (idle_inc == timeout_reg) && !match_hit;
  assign cfg_open    = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign cfg_legal   = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Priority inside HUNT: abort, then match (with limit), then timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_ARMED;
      S_ARMED: state_next = abort ? S_DONE : S_HUNT;
      S_HUNT: begin
        if (abort) begin
          state_next = S_DONE;
        end else if (match_hit && limit_hit) begin
          state_next = S_DONE;
        end else if (timeout_hit) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  if (start) state_next = S_ARMED;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pattern_reg      <= '0;
      len_reg          <= LEN_W'(1);
      overlap_reg      <= 1'b0;
      limit_reg        <= '0;
      timeout_reg      <= '0;
      history_reg      <= '0;
      bits_seen_reg    <= '0;
      shifted_reg      <= 1'b0;
      count_reg        <= '0;
      idle_reg         <= '0;
      detected_reg     <= 1'b0;
      timeout_flag_reg <= 1'b0;
      cfg_err_reg      <= 1'b0;
    end else begin
      if (cfg_we && cfg_open) begin
        if (cfg_legal) begin
          pattern_reg <= cfg_pattern;
          len_reg     <= cfg_len;
          overlap_reg <= cfg_overlap;
          limit_reg   <= cfg_limit;
          timeout_reg <= cfg_timeout;
          cfg_err_reg <= 1'b0;
        end else begin
          cfg_err_reg <= 1'b1;
        end
      end

      detected_reg <= match_hit && !abort;

      case (state_reg)
        S_ARMED: begin
          history_reg      <= '0;
          bits_seen_reg    <= '0;
          shifted_reg      <= 1'b0;
          count_reg        <= '0;
          idle_reg         <= '0;
          timeout_flag_reg <= 1'b0;
        end
        S_HUNT: begin
          if (abort) begin
            shifted_reg <= 1'b0;
          end else begin
            shifted_reg <= data_valid;
            if (data_valid) begin
              history_reg <= {history_reg[MAX_LEN-2:0], data_in};
            end
            // Without overlap the bit arriving alongside the match is the first fresh one.
            if (match_hit && !overlap_reg) begin
              bits_seen_reg <= data_valid ? LEN_W'(1) : '0;
            end else if (data_valid && (bits_seen_reg < MAX_LEN_L)) begin
              bits_seen_reg <= bits_seen_reg + LEN_W'(1);
            end
            if (match_hit) begin
              count_reg <= count_inc;
              idle_reg  <= '0;
            end else begin
              idle_reg  <= idle_inc;
            end
            if (timeout_hit) begin
              timeout_flag_reg <= 1'b1;
            end
          end
        end
        default: shifted_reg <= 1'b0;
      endcase
    end
  end

  assign detected     = detected_reg;
  assign match_count  = count_reg;
  assign busy         = (state_reg == S_ARMED) || (state_reg == S_HUNT);
  assign done         = (state_reg == S_DONE);
  assign timeout_flag = timeout_flag_reg;
  assign cfg_err      = cfg_err_reg;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: overlap modes, match limit, timeout, config
// rejection, abort priority and mid-run reset, each against hand-computed values.
module tb_seq_detect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic [7:0]  cfg_limit;
  logic [15:0] cfg_timeout;
  logic        start;
  logic        abort;
  logic        data_valid;
  logic        data_in;
  logic        detected;
  logic [7:0]  match_count;
  logic        busy;
  logic        done;
  logic        timeout_flag;
  logic        cfg_err;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [7:0] det_vec;
  logic [7:0] stream;

  seq_detect_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8), .TO_W(16)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_limit(cfg_limit),
    .cfg_timeout(cfg_timeout), .start(start), .abort(abort),
    .data_valid(data_valid), .data_in(data_in), .detected(detected),
    .match_count(match_count), .busy(busy), .done(done),
    .timeout_flag(timeout_flag), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic write_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                           input logic [7:0] lim, input logic [15:0] to);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cfg_limit = lim; cfg_timeout = to;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  // Leaves the DUT in HUNT, ready to sample bits on the next edge.
  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic send_bit(input logic b);
    data_valid = 1'b1; data_in = b;
    tick();
    data_valid = 1'b0;
  endtask

  // det_vec[k] = detected sampled after the edge that follows 1-based bit k.
  task automatic run_stream(input logic [7:0] bits, input int n);
    det_vec = '0;
    for (int i = 0; i < n; i++) begin
      send_bit(bits[i]);
      det_vec[i] = detected;
      $display("bit %0d=%0b detected=%0b count=%0d", i + 1, bits[i], detected, match_count);
    end
    tick();
    det_vec[n] = detected;
  endtask

  initial begin
    reset = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = 4'd1; cfg_overlap = 1'b0;
    cfg_limit = '0; cfg_timeout = '0; start = 1'b0; abort = 1'b0;
    data_valid = 1'b0; data_in = 1'b0;
    tick(); tick();
    check("rst_detected", detected, 0);
    check("rst_count", match_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tflag", timeout_flag, 0);
    check("rst_cfg_err", cfg_err, 0);
    reset = 1'b1;
    tick();

    // Overlapping 1011 in 1,0,1,1,0,1,1: hits after bits 4 and 7.
    write_cfg(8'b0000_1011, 4'd4, 1'b1, 8'd0, 16'd0);
    start_run();
    check("ov1_busy_hunt", busy, 1);
    stream = 8'b0110_1101;
    run_stream(stream, 7);
    check("ov1_det_vec", det_vec, 8'h90);
    check("ov1_count", match_count, 2);
    check("ov1_busy", busy, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("ov1_abort_done", done, 1);
    check("ov1_abort_count", match_count, 2);

    // Same stream without overlap: only the first hit.
    write_cfg(8'b0000_1011, 4'd4, 1'b0, 8'd0, 16'd0);
    start_run();
    run_stream(stream, 7);
    check("ov0_det_vec", det_vec, 8'h10);
    check("ov0_count", match_count, 1);
    abort = 1'b1; tick(); abort = 1'b0;

    // Limit 3 with pattern 11: hits after bits 2,3,4, then DONE.
    write_cfg(8'b0000_0011, 4'd2, 1'b1, 8'd3, 16'd0);
    start_run();
    run_stream(8'b0001_1111, 5);
    check("lim_det_vec", det_vec, 8'h1C);
    check("lim_count", match_count, 3);
    check("lim_done", done, 1);
    check("lim_busy", busy, 0);
    tick();
    check("lim_count_hold", match_count, 3);

    // Timeout 10 with a constant-0 stream against pattern 1.
    write_cfg(8'b0000_0001, 4'd1, 1'b0, 8'd0, 16'd10);
    start_run();
    data_valid = 1'b1; data_in = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("to_not_yet_done", done, 0);
    check("to_not_yet_flag", timeout_flag, 0);
    tick();
    data_valid = 1'b0;
    $display("timeout run: done=%0b tflag=%0b count=%0d", done, timeout_flag, match_count);
    check("to_done", done, 1);
    check("to_flag", timeout_flag, 1);
    check("to_count", match_count, 0);

    // Rejected writes keep the pattern-1/len-1 config.
    write_cfg(8'b0000_0011, 4'd0, 1'b1, 8'd0, 16'd0);
    check("len0_err", cfg_err, 1);
    write_cfg(8'b0000_0011, 4'd9, 1'b1, 8'd0, 16'd0);
    check("len9_err", cfg_err, 1);
    start_run();
    check("start_clears_tflag", timeout_flag, 0);
    run_stream(8'b0000_0001, 1);
    check("old_cfg_det_vec", det_vec, 8'h02);
    write_cfg(8'b0000_0000, 4'd2, 1'b0, 8'd0, 16'd0);
    check("hunt_cfg_err_kept", cfg_err, 1);
    run_stream(8'b0000_0001, 1);
    check("hunt_cfg_ignored", det_vec, 8'h02);
    check("hunt_cfg_count", match_count, 2);
    abort = 1'b1; tick(); abort = 1'b0;
    write_cfg(8'b0000_0011, 4'd2, 1'b1, 8'd0, 16'd0);
    check("legal_clears_err", cfg_err, 0);

    // Abort together with the final matching bit of 1,1,0,1,1.
    start_run();
    run_stream(8'b0000_1011, 4);
    check("ab_pre_count", match_count, 1);
    data_valid = 1'b1; data_in = 1'b1; abort = 1'b1;
    tick();
    data_valid = 1'b0; abort = 1'b0;
    check("ab_det0", detected, 0);
    check("ab_done", done, 1);
    tick();
    check("ab_det1", detected, 0);
    check("ab_count", match_count, 1);

    // Reset in the middle of a hunt with a match pending.
    write_cfg(8'b0000_0011, 4'd0, 1'b1, 8'd0, 16'd0);
    start_run();
    run_stream(8'b0000_0111, 3);
    data_valid = 1'b1; data_in = 1'b1; reset = 1'b0;
    tick();
    data_valid = 1'b0;
    check("mid_rst_detected", detected, 0);
    check("mid_rst_count", match_count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_tflag", timeout_flag, 0);
    check("mid_rst_cfg_err", cfg_err, 0);
    reset = 1'b1;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable serial sequence-detector controller. It holds a configurable bit pattern, length, overlap mode and match limit, and sequences a detection run: arm, hunt, count matches, then stop on the limit, a timeout or an abort. It sits between the register/config logic and the serial data stream, and produces a per-match pulse plus run status for the rest of the design.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..15)
LEN_W, 4, width of cfg_len
CNT_W, 8, width of the match counter and of cfg_limit
TO_W, 16, width of cfg_timeout and of the idle-cycle counter

Ports:
clk  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-low reset
cfg_we  input  1  config write strobe; accepted only in IDLE or DONE
cfg_pattern  input  MAX_LEN  pattern; bit 0 is the most recently received bit
cfg_len  input  LEN_W  pattern length; legal range 1..MAX_LEN
cfg_overlap  input  1  1 = overlapping matches allowed; 0 = history restarts after each match
cfg_limit  input  CNT_W  number of matches that ends the run; 0 = unlimited
cfg_timeout  input  TO_W  cycles without a match before timeout; 0 = disabled
start  input  1  begins a run (IDLE/DONE only)
abort  input  1  ends a run immediately
data_valid  input  1  qualifies data_in
data_in  input  1  serial data bit
detected  output  1  one-cycle pulse per match
match_count  output  CNT_W  matches in the current or last run
busy  output  1  high in ARMED and HUNT
done  output  1  high in DONE
timeout_flag  output  1  last run ended by timeout (sticky until the next start)
cfg_err  output  1  last cfg_we carried an illegal cfg_len

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE; shadow config = pattern 0, len 1, overlap 0, limit 0, timeout 0; history and bit counter cleared.
- Reset values of outputs: detected, match_count, busy, done, timeout_flag and cfg_err are all 0.
- Config write (cfg_we in IDLE/DONE): all fields latch into shadow registers.
  - cfg_len of 0 or greater than MAX_LEN: the write is rejected, shadow registers are unchanged, cfg_err=1.
  - Legal write: cfg_err=0.
  - cfg_we in ARMED/HUNT is ignored and cfg_err is unchanged.
- States: IDLE, ARMED, HUNT, DONE.
  - IDLE --start--> ARMED.
  - ARMED: one cycle; clears history, bit counter, match_count, idle counter and timeout_flag; goes to HUNT. data_valid is ignored in ARMED.
  - HUNT: on data_valid, history <= {history[MAX_LEN-2:0], data_in}; the bit counter saturates at MAX_LEN.
    - Match condition: the registered data_valid shifted a bit in, bits_seen >= len, and the low len bits of history equal the low len bits of pattern. detected pulses the cycle after the matching bit's clock edge, i.e. one cycle of latency from the edge that samples the last pattern bit.
    - On a match: match_count increments (saturating at all-ones) and the idle counter clears.
    - Overlap 0: the bit counter clears after a match, so the next match needs len fresh bits.
    - Overlap 1: the bit counter is kept.
    - If limit is not 0 and the incremented count equals limit: go to DONE in the same cycle as the detected pulse.
  - Timeout: the idle counter increments every HUNT cycle (valid or not). When it reaches cfg_timeout (and cfg_timeout is not 0) with no match that cycle: go to DONE, timeout_flag=1.
  - abort in ARMED/HUNT: go to DONE next cycle, no detected pulse, match_count holds. abort in IDLE/DONE: no effect.
  - DONE: done=1; match_count holds; start --> ARMED.
- Simultaneous events:
  - abort has priority over a match and over a timeout in the same cycle.
  - A match has priority over a timeout in the same cycle.
  - start together with cfg_we in IDLE/DONE: the config latches first, and the run uses the new config.
- Reset mid-run: returns to IDLE with all outputs 0 on the next edge.

Test Plan:
- Reset, then cfg pattern=8'b0000_1011, len=4, overlap=1, limit=0; start; stream 1,0,1,1,0,1,1 -> detected pulses after bit 4 and bit 7; match_count=2; busy=1.
- Same stream with overlap=0 -> a single pulse after bit 4; match_count=1.
- limit=3, pattern=2'b11, len=2, overlap=1; stream five 1s -> pulses after bits 2, 3 and 4; DONE after the 3rd pulse; match_count=3; done=1; busy=0; bit 5 ignored.
- timeout=10, pattern never present (constant 0 stream) -> DONE after 10 HUNT cycles; timeout_flag=1; match_count=0.
- cfg_we with len=0, and then with len=9 -> cfg_err=1 and the previous config is still used on the next run; cfg_we during HUNT -> ignored.
- abort on the same cycle as a matching bit -> no detected pulse, DONE, count unchanged; reset=0 mid-HUNT -> IDLE, all outputs 0.
